mmio_uart_tx: RTL

Memory-mapped UART transmitter on the processor's data-memory port, alongside the data RAM. Snoops the M-stage address, write data and write-enable, decodes a two-register window, buffers written bytes in a FIFO and serialises them 8N1 (optionally 8E1) on `tx_o`. Gives test programs running from ROM an observable output channel without a debugger. The top level gates RAM writes with `!sel_o` and muxes `rdata_o` into the core's read-data path when `sel_o` is high.

---
 rtl/mmio_uart_tx.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with TX FIFO; even parity bit when UART_TX_PARITY_EN is defined
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic        sel_o,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            pop;
  logic            bit_end;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;

  logic            fifo_empty, fifo_full, push;
  logic            wr_txdata, wr_status;
  logic [7:0]      head;
  logic [7:0]      cnt8;
  logic [31:0]     status;
  logic            unused_wdata;

`ifdef UART_TX_PARITY_EN
  logic            par_q;
`endif

  // register window decode and the byte pushed into the FIFO
  assign sel_o      = (addr_i[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata  = we_i && (addr_i == BASE_ADDR);
  assign wr_status  = we_i && (addr_i == BASE_ADDR + 32'd4);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign push       = wr_txdata && (!fifo_full || pop);
  assign head       = mem[rptr_q];
  assign bit_end    = (baud_q == BAUD_LAST);
  assign unused_wdata = ^wdata_i[31:8];

  // STATUS is built from registered state only, so a load sees the last edge
  assign cnt8    = 8'(count_q);
  assign status  = {16'h0000, cnt8, 4'h0, ovf_q, (state_q != IDLE), fifo_empty, fifo_full};
  assign rdata_o = (addr_i == BASE_ADDR + 32'd4) ? status : 32'h0;
  assign tx_o    = tx_q;
  assign busy_o  = !fifo_empty || (state_q != IDLE);

  // next-state, pop decision and the line level for the next cycle
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = head;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // FSM state, baud timer, shifter and the glitch-free registered line
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      if (pop) par_q <= ^head;
`endif
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= wdata_i[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_txdata && !push) ovf_q <= 1'b1;
      else if (wr_status)     ovf_q <= 1'b0;
    end
  end

endmodule
